// File: rtl/proc_ctrl_pkg.sv
// Shared state encoding and processor opcodes for the instruction sequencer
// and the 16-bit processor it drives.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_FINISH = 3'd5,
    ST_ERR    = 3'd6,
    ST_PAUSE  = 3'd7
  } seq_state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Busy covers every state that owns an instruction in flight (PAUSE included).
  function automatic logic is_busy(input seq_state_t s);
    return !((s == ST_IDLE) || (s == ST_FINISH) || (s == ST_ERR));
  endfunction

endpackage

// File: rtl/instr_sequencer_seq_watchdog.sv
// Done-timeout watchdog: clearable saturating counter with enable.
// o_expired flags the enabled cycle in which the count reaches (or sits at) TIMEOUT.
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LP_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] LP_PRE = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LP_MAX)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Looking one step ahead lets the FSM leave EXEC on the very edge the count hits TIMEOUT.
  assign o_expired = i_en && !i_clr && ((r_count == LP_PRE) || (r_count == LP_MAX));

endmodule

// File: rtl/instr_sequencer.sv
// Program controller: fetches ProgLen words from a synchronous ROM and issues each over
// the DIN/Run/Done handshake. Define INSTR_SEQUENCER_SINGLE_STEP_EN to add StepMode/Step pausing.
module instr_sequencer
  import proc_ctrl_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Resetn,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  input  logic          StepMode,
  input  logic          Step,
`endif
  input  logic          Start,
  input  logic          Halt,
  input  logic [AW:0]   ProgLen,
  output logic [AW-1:0] RomAddr,
  input  logic [DW-1:0] RomData,
  output logic [DW-1:0] DIN,
  output logic          Run,
  input  logic          Done,
  output logic          Busy,
  output logic          Finished,
  output logic          Error,
  output logic [AW-1:0] PC
);

  seq_state_t    r_state;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_len;
  logic [DW-1:0] r_din;
  logic          r_halt_pend;

  logic w_start_ok;
  logic w_last;
  logic w_halt_now;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_expired;

  assign w_start_ok = Start && !is_busy(r_state);
  // One extra bit so a full 2^AW-word program still terminates.
  assign w_last     = (({1'b0, r_pc} + (AW+1)'(1)) == r_len);
  assign w_halt_now = r_halt_pend || Halt;
  assign w_wd_en    = (r_state == ST_EXEC);
  assign w_wd_clr   = w_start_ok || ((r_state == ST_EXEC) && Done);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_len       <= '0;
      r_din       <= '0;
      r_halt_pend <= 1'b0;
    end else begin
      if (is_busy(r_state) && Halt) begin
        r_halt_pend <= 1'b1;
      end
      case (r_state)
        ST_IDLE, ST_FINISH, ST_ERR: begin
          if (Start) begin
            r_len       <= ProgLen;
            r_pc        <= '0;
            r_halt_pend <= 1'b0;
            r_state     <= (ProgLen == '0) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_din   <= RomData;
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (Done) begin
            r_pc <= r_pc + AW'(1);
            if (w_last) begin
              r_state <= ST_FINISH;
            end else if (w_halt_now) begin
              r_state     <= ST_IDLE;
              r_halt_pend <= 1'b0;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
            end else if (StepMode) begin
              r_state <= ST_PAUSE;
`endif
            end else begin
              r_state <= ST_FETCH;
            end
          end else if (w_expired) begin
            r_state <= ST_ERR;
          end
        end
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        ST_PAUSE: begin
          if (w_halt_now) begin
            r_state     <= ST_IDLE;
            r_halt_pend <= 1'b0;
          end else if (Step) begin
            r_state <= ST_FETCH;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign RomAddr  = r_pc;
  assign PC       = r_pc;
  assign DIN      = r_din;
  assign Run      = (r_state == ST_ISSUE);
  assign Busy     = is_busy(r_state);
  assign Finished = (r_state == ST_FINISH);
  assign Error    = (r_state == ST_ERR);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: ROM and processor models, DIN checked on every Run.
// Exercises INSTR_SEQUENCER_SINGLE_STEP_EN stepping when that macro is defined.
module tb_instr_sequencer;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic        Halt = 1'b0;
  logic [8:0]  ProgLen = '0;
  logic [7:0]  RomAddr;
  logic [15:0] RomData = '0;
  logic [15:0] DIN;
  logic        Run;
  logic        Done;
  logic        Busy;
  logic        Finished;
  logic        Error;
  logic [7:0]  PC;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic        StepMode = 1'b0;
  logic        Step = 1'b0;
`endif

  logic        done_model = 1'b0;
  logic        done_spur = 1'b0;
  logic        done_en = 1'b1;
  logic        prev_run = 1'b0;
  logic [15:0] rom [0:255];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          run_cnt = 0;
  int          run_base;

  assign Done = done_model | done_spur;

  instr_sequencer dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    .StepMode (StepMode),
    .Step     (Step),
`endif
    .Start    (Start),
    .Halt     (Halt),
    .ProgLen  (ProgLen),
    .RomAddr  (RomAddr),
    .RomData  (RomData),
    .DIN      (DIN),
    .Run      (Run),
    .Done     (Done),
    .Busy     (Busy),
    .Finished (Finished),
    .Error    (Error),
    .PC       (PC)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) RomData <= rom[RomAddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Processor model: Done two cycles after each observed Run.
  initial forever begin
    @(posedge Clock); #1;
    if (Run && done_en) begin
      @(posedge Clock); @(posedge Clock); #1;
      done_model = 1'b1;
      @(posedge Clock); #1;
      done_model = 1'b0;
    end
  end

  // Scoreboard consumer: every Run must match the next expected instruction word.
  initial forever begin
    @(posedge Clock); #1;
    if (Run) begin
      run_cnt++;
      $display("run %0d pc=%0d din=%h", run_cnt, PC, DIN);
      check("run_single_cycle", prev_run, 1'b0);
      check("run_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("din", DIN, exp_q.pop_front());
    end
    prev_run = Run;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic push_prog(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(rom[i]);
  endtask

  task automatic start_prog(input int len);
    Start = 1'b1;
    ProgLen = 9'(len);
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    for (int k = 0; k < 40; k++) begin
      @(posedge Clock); #1;
      if (Run) break;
    end
    check(tag, Run, 1'b1);
  endtask

  task automatic wait_finished(input string tag);
    for (int k = 0; k < 200; k++) begin
      if (Finished) break;
      @(posedge Clock); #1;
    end
    check(tag, Finished, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h8000 ^ 16'(i * 257);
    rom[0] = 16'h1005;
    rom[1] = 16'h2203;
    rom[2] = 16'h4401;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("rst_run", Run, 0);
    check("rst_busy", Busy, 0);
    check("rst_finished", Finished, 0);
    check("rst_error", Error, 0);
    check("rst_pc", PC, 0);
    check("rst_din", DIN, 0);
    Resetn = 1'b1;
    repeat (2) @(posedge Clock);
    #1;

    // Three-instruction program, first Run three cycles after Start
    push_prog(3);
    run_base = run_cnt;
    Start = 1'b1;
    ProgLen = 9'd3;
    begin
      int lat;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(posedge Clock); #1;
        Start = 1'b0;
        if (Run) begin
          lat = k;
          break;
        end
      end
      check("run_latency", lat, 3);
    end
    wait_finished("prog3_finished");
    check("prog3_pc", PC, 3);
    check("prog3_busy", Busy, 0);
    check("prog3_runs", run_cnt - run_base, 3);
    check("prog3_queue", exp_q.size(), 0);

    // Zero-length program
    run_base = run_cnt;
    start_prog(0);
    check("len0_finished", Finished, 1);
    check("len0_busy", Busy, 0);
    check("len0_romaddr", RomAddr, 0);
    repeat (4) @(posedge Clock);
    #1;
    check("len0_runs", run_cnt - run_base, 0);

    // Halt during the second instruction's EXEC
    push_prog(2);
    run_base = run_cnt;
    start_prog(4);
    wait_run("halt_run1");
    wait_run("halt_run2");
    @(posedge Clock); #1;
    Halt = 1'b1;
    @(posedge Clock); #1;
    Halt = 1'b0;
    for (int k = 0; k < 20 && Busy; k++) begin
      @(posedge Clock); #1;
    end
    check("halt_idle_busy", Busy, 0);
    check("halt_finished", Finished, 0);
    check("halt_pc", PC, 2);
    repeat (10) @(posedge Clock);
    #1;
    check("halt_runs", run_cnt - run_base, 2);
    push_prog(4);
    start_prog(4);
    check("restart_romaddr", RomAddr, 0);
    wait_finished("restart_finished");
    check("restart_pc", PC, 4);

    // Done withheld: timeout to ERR
    done_en = 1'b0;
    push_prog(1);
    start_prog(2);
    wait_run("to_run");
    repeat (15) @(posedge Clock);
    #1;
    check("to_error_early", Error, 0);
    @(posedge Clock); #1;
    check("to_error", Error, 1);
    check("to_pc", PC, 0);
    check("to_busy", Busy, 0);
    repeat (5) @(posedge Clock);
    #1;
    check("to_error_sticky", Error, 1);
    done_en = 1'b1;
    push_prog(2);
    start_prog(2);
    check("to_error_cleared", Error, 0);
    wait_finished("to_restart_finished");
    check("to_restart_pc", PC, 2);

    // Spurious Done in FETCH/WAIT/ISSUE and Start while Busy
    push_prog(2);
    run_base = run_cnt;
    start_prog(2);
    done_spur = 1'b1;
    Start = 1'b1;
    ProgLen = 9'd0;
    for (int k = 0; k < 3; k++) begin
      check("spur_pc", PC, 0);
      check("spur_busy", Busy, 1);
      @(posedge Clock); #1;
    end
    done_spur = 1'b0;
    Start = 1'b0;
    check("spur_exec_pc", PC, 0);
    check("spur_exec_busy", Busy, 1);
    wait_finished("spur_finished");
    check("spur_pc_final", PC, 2);
    check("spur_runs", run_cnt - run_base, 2);

    // Reset during the second instruction's EXEC
    push_prog(3);
    start_prog(3);
    wait_run("rst_exec_run1");
    wait_run("rst_exec_run2");
    @(posedge Clock); #1;
    check("rst_exec_pre_pc", PC, 1);
    #2 Resetn = 1'b0;
    #1;
    check("rst_exec_pc", PC, 0);
    check("rst_exec_busy", Busy, 0);
    check("rst_exec_run", Run, 0);
    check("rst_exec_error", Error, 0);
    exp_q.delete();
    @(posedge Clock); #1;
    Resetn = 1'b1;
    repeat (5) @(posedge Clock);
    #1;

    // Reset while Run is high
    push_prog(2);
    start_prog(2);
    wait_run("rst_issue_run");
    #2 Resetn = 1'b0;
    #1;
    check("rst_issue_run_low", Run, 0);
    check("rst_issue_busy", Busy, 0);
    exp_q.delete();
    @(posedge Clock); #1;
    Resetn = 1'b1;
    repeat (5) @(posedge Clock);
    #1;

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    // Single-step: one instruction per Step pulse
    StepMode = 1'b1;
    push_prog(3);
    run_base = run_cnt;
    start_prog(3);
    for (int s = 1; s <= 2; s++) begin
      wait_run("step_run");
      repeat (8) @(posedge Clock);
      #1;
      check("step_pause_pc", PC, 8'(s));
      check("step_pause_busy", Busy, 1);
      check("step_pause_runs", run_cnt - run_base, s);
      Step = 1'b1;
      @(posedge Clock); #1;
      Step = 1'b0;
    end
    wait_run("step_run_last");
    wait_finished("step_finished");
    check("step_pc", PC, 3);
    StepMode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program controller that drives the 16-bit processor's DIN/Run/Done handshake from a synchronous instruction ROM.
- Fetches words at PC = 0 .. ProgLen-1, issues each as one Run pulse, and waits for Done before advancing.
- Sits between the instruction ROM and the processor top level; replaces manual switch/Run stimulus on the board.
- Provides start/halt control, completion and error flags, and a Done-timeout watchdog.

Parameters:
- AW, 8, ROM address width; PC width.
- DW, 16, instruction word width; matches processor DIN.
- TIMEOUT, 15, maximum cycles in EXEC waiting for Done before error.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Resetn  in  1  reset, asynchronous, active-low.
- Start  in  1  begin program at PC=0; sampled only in IDLE, FINISH or ERR.
- Halt  in  1  stop after the current instruction completes.
- ProgLen  in  AW+1  number of instructions; sampled on accepted Start.
- RomAddr  out  AW  ROM read address; equals PC.
- RomData  in  DW  ROM read data, valid 1 cycle after RomAddr.
- DIN  out  DW  registered instruction word to processor.
- Run  out  1  one-cycle issue pulse to processor.
- Done  in  1  processor completion pulse.
- Busy  out  1  high in any state other than IDLE/FINISH/ERR.
- Finished  out  1  high in FINISH.
- Error  out  1  high in ERR (sticky until Start).
- PC  out  AW  current instruction index.

Behaviour:
- Reset (async on Resetn=0): state IDLE, PC=0, DIN=0, Run=0, Busy=0, Finished=0, Error=0, latched length=0, timeout counter=0.
- States: IDLE, FETCH, WAIT, ISSUE, EXEC, FINISH, ERR. Outputs are decoded from registered state (Moore).
- IDLE/FINISH/ERR + Start=1: latch ProgLen and set PC=0. ProgLen=0 -> FINISH; otherwise -> FETCH.
- FETCH: RomAddr=PC, then WAIT.
- WAIT: DIN<=RomData at end of cycle, then ISSUE.
- ISSUE: Run=1 for exactly one cycle, then EXEC. DIN holds stable from ISSUE through end of EXEC.
- EXEC: Run=0; timeout counter increments each cycle.
  - On Done=1: PC<=PC+1 and counter cleared.
  - If PC+1==length: -> FINISH.
  - Else if Halt is pending: -> IDLE.
  - Else: -> FETCH.
- Latency: Start edge to Run high = 3 cycles (FETCH, WAIT, ISSUE). Minimum per instruction = 4 cycles plus processor execution.
- Timeout: counter reaches TIMEOUT with no Done -> ERR. PC holds the faulting index.
- Done outside EXEC is ignored; it neither advances PC nor clears the counter.
- Done in the ISSUE cycle is ignored; the processor cannot complete before T1.
- Halt: a pending flag set whenever Halt=1 while Busy.
  - Takes effect only at instruction boundaries; never aborts mid-instruction.
  - Halt in FETCH/WAIT/ISSUE still completes that instruction.
  - Cleared on entering IDLE.
- Start while Busy is ignored.
- Start and Halt both asserted in IDLE: Start wins; the Halt flag is not set from IDLE.
- PC wraps modulo 2^AW. With ProgLen = 2^AW, the final instruction's PC+1 comparison uses AW+1 bits, so the program finishes correctly.
- Reset mid-operation: immediate return to IDLE; Run is forced to 0 asynchronously.

Optional Feature:
- Macro INSTR_SEQUENCER_SINGLE_STEP_EN.
- Defined:
  - Adds input StepMode (1 bit) and input Step (1 bit), plus state PAUSE.
  - With StepMode=1, EXEC+Done goes to PAUSE instead of FETCH. PC is already incremented on entry to PAUSE.
  - Step=1 in PAUSE -> FETCH.
  - Halt in PAUSE -> IDLE.
  - Busy stays 1 in PAUSE.
  - The final instruction still goes to FINISH.
- Undefined: no extra ports or state; behaviour exactly as above.

Decomposition:
- Package proc_ctrl_pkg holds:
  - state encoding constants (3-bit: IDLE=0, FETCH=1, WAIT=2, ISSUE=3, EXEC=4, FINISH=5, ERR=6, PAUSE=7);
  - processor opcode constants (mv=000, mvt=001, add=010, sub=011), shared with the processor.
- One sub-module: seq_watchdog, a clearable saturating counter with enable. Outputs expired when count==TIMEOUT.

Test Plan:
- Reset, then ProgLen=3, ROM = {16'h1005, 16'h2203, 16'h4401}, Done returned 2 cycles after each Run -> DIN sequence 1005/2203/4401, three single-cycle Run pulses, first Run 3 cycles after Start, Finished=1, PC=3.
- ProgLen=0 with Start -> Finished=1 next cycle, no Run pulse, RomAddr stays 0.
- ProgLen=4, Halt pulsed during the 2nd instruction's EXEC -> 2nd instruction completes, state IDLE with PC=2, no third Run; a later Start restarts at PC=0.
- ProgLen=2, Done withheld for the 1st instruction -> Error=1 after TIMEOUT=15 EXEC cycles, PC=0, Busy=0; Start clears Error.
- Spurious Done during FETCH/WAIT/ISSUE and extra Start while Busy -> no PC change, no restart.
- Resetn low during EXEC -> Run, Busy, Error, PC all 0 immediately. With the macro defined: StepMode=1 gives one instruction per Step pulse.
